fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the RV32I pipeline. Holds the program counter, drives the word address of the combinational instruction ROM, and registers the returned instruction with its PC into the IF/ID pipeline register. It honours load-use stalls from decode and branch/jump redirects from execute, squashing the wrong-path instruction with a NOP bubble.

## Interface
- ROM_ADDR_WIDTH, 10, ROM word-address width (1024 × 32-bit words)
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0, x0, 0)

- CLK  input  1  sole clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high; sampled on CLK rising edge
- STALL  input  1  from hazard unit: hold PC and IF/ID register
- BRANCH_TAKEN  input  1  from EX: redirect fetch to BRANCH_TARGET
- BRANCH_TARGET  input  32  byte address of redirect
- ROM_ADDRESS  output  ROM_ADDR_WIDTH  word address to ROM, = PC[ROM_ADDR_WIDTH+1:2]
- ROM_DATA  input  32  combinational ROM read data for ROM_ADDRESS
- INSTRUCTION  output  32  IF/ID instruction
- PC_OUT  output  32  IF/ID PC of INSTRUCTION
- VALID  output  1  IF/ID holds a real (non-bubble) instruction
- FETCH_COUNT  output  32  number of instructions accepted into IF/ID

## Operation
- State: PC (32b), IF/ID {INSTRUCTION, PC_OUT, VALID}, FETCH_COUNT.
- ROM_ADDRESS is combinational from PC; PC[1:0] are never used for addressing.
- Per edge, priority RESET > BRANCH_TAKEN > STALL > normal:
  - RESET: PC←RESET_PC; INSTRUCTION←NOP_INSTR; PC_OUT←0; VALID←0; FETCH_COUNT←0.
  - BRANCH_TAKEN: PC←{BRANCH_TARGET[31:2],2'b00}; INSTRUCTION←NOP_INSTR; PC_OUT←0; VALID←0; FETCH_COUNT unchanged. Overrides a simultaneous STALL (stalled instruction is on the wrong path).
  - STALL (no branch): PC, INSTRUCTION, PC_OUT, VALID, FETCH_COUNT all hold.
  - Normal: INSTRUCTION←ROM_DATA; PC_OUT←PC; VALID←1; PC←PC+4; FETCH_COUNT←FETCH_COUNT+1.
- PC arithmetic modulo 2^32; FETCH_COUNT wraps 0xFFFFFFFF→0.
- PC beyond ROM range aliases: ROM_ADDRESS takes low bits only (PC 0x00000FFC→ROM 1023, next PC 0x00001000→ROM 0). No error flag.
- Misaligned BRANCH_TARGET silently aligned by clearing bits [1:0].

## Timing
- Fetch latency 1 cycle: instruction at PC appears on INSTRUCTION the edge after PC is presented.
- First valid instruction (address RESET_PC) on INSTRUCTION one edge after the first edge with RESET low.
- Branch penalty from this stage: 1 bubble (VALID=0 for one cycle), target instruction valid the following edge unless stalled.
- Stall of N cycles holds IF/ID for N cycles; no instruction skipped or duplicated.
- RESET asserted mid-stream takes effect at the next edge regardless of STALL/BRANCH_TAKEN.

## Structure
- Shared package (rv32i_pkg): NOP_INSTR constant, XLEN=32, ROM_ADDR_WIDTH default; reused by decode and hazard logic.
- Single module, no sub-modules; IF/ID register lives here, not in decode.

## Test plan
- Reset/streaming: ROM words 0..4 = 0x00000013, 0x00100093, 0x00100313, 0x00400613, 0x00602023; release RESET → successive cycles INSTRUCTION/PC_OUT = (0x00000013,0), (0x00100093,4), (0x00100313,8), …, VALID=1, FETCH_COUNT 1,2,3…
- Stall: STALL high 2 cycles while INSTRUCTION=0x00100313/PC_OUT=8 → held 2 cycles, ROM_ADDRESS stays 3, then 0x00400613/0x0C, FETCH_COUNT increments by exactly 1 after release.
- Branch: BRANCH_TAKEN with BRANCH_TARGET=0x14 while PC=0x24 → next cycle INSTRUCTION=0x00000013, VALID=0, PC_OUT=0, ROM_ADDRESS=5; following cycle PC_OUT=0x14, VALID=1.
- Branch+stall same cycle: both high, target 0x08 → bubble issued, PC=0x08, stall ignored; next edge PC_OUT=0x08.
- Wrap and alignment: redirect to 0x00000FFE → PC=0xFFC, ROM_ADDRESS=1023; next PC=0x1000, ROM_ADDRESS=0.
- Reset mid-operation: RESET high with STALL and BRANCH_TAKEN high at PC=0x40 → PC=0, INSTRUCTION=0x00000013, VALID=0, FETCH_COUNT=0 next edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions used by the fetch, decode and hazard logic.
package rv32i_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned ROM_ADDR_WIDTH = 10;
    localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;

    // Instruction fetch ignores byte offsets, so redirect targets are forced to word alignment.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ROM word addressing and the IF/ID pipeline register.
module fetch_stage #(
    parameter int unsigned                     ROM_ADDR_WIDTH = rv32i_pkg::ROM_ADDR_WIDTH,
    parameter logic [rv32i_pkg::XLEN-1:0]      RESET_PC       = 32'h0000_0000,
    parameter logic [rv32i_pkg::XLEN-1:0]      NOP_INSTR      = rv32i_pkg::NOP_INSTR
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      STALL,
    input  logic                      BRANCH_TAKEN,
    input  logic [31:0]               BRANCH_TARGET,
    output logic [ROM_ADDR_WIDTH-1:0] ROM_ADDRESS,
    input  logic [31:0]               ROM_DATA,
    output logic [31:0]               INSTRUCTION,
    output logic [31:0]               PC_OUT,
    output logic                      VALID,
    output logic [31:0]               FETCH_COUNT
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    // Out-of-range PCs alias onto the ROM by dropping the upper bits.
    assign ROM_ADDRESS = pc_q[ROM_ADDR_WIDTH+1:2];

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        count_d  = count_q;
        if (BRANCH_TAKEN) begin
            // Redirect wins over stall: whatever is held in IF/ID is on the wrong path.
            pc_d     = rv32i_pkg::align_word(BRANCH_TARGET);
            instr_d  = NOP_INSTR;
            pc_out_d = '0;
            valid_d  = 1'b0;
        end else if (!STALL) begin
            instr_d  = ROM_DATA;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            count_d  = count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign INSTRUCTION = instr_q;
    assign PC_OUT      = pc_out_q;
    assign VALID       = valid_q;
    assign FETCH_COUNT = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver queues expected IF/ID state, monitor checks each cycle.
module tb_fetch_stage;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [9:0]  ROM_ADDRESS;
    logic [31:0] ROM_DATA;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC_OUT;
    logic        VALID;
    logic [31:0] FETCH_COUNT;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] cnt;
        logic [9:0]  addr;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    logic [31:0] rom [1024];
    int          n_vec  = 0;
    int          n_fail = 0;

    fetch_stage dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .ROM_ADDRESS   (ROM_ADDRESS),
        .ROM_DATA      (ROM_DATA),
        .INSTRUCTION   (INSTRUCTION),
        .PC_OUT        (PC_OUT),
        .VALID         (VALID),
        .FETCH_COUNT   (FETCH_COUNT)
    );

    assign ROM_DATA = rom[ROM_ADDRESS];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Monitor: IF/ID and ROM_ADDRESS are sampled mid-cycle, away from the rising edge.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (INSTRUCTION !== e.instr || PC_OUT !== e.pc || VALID !== e.valid ||
                FETCH_COUNT !== e.cnt || ROM_ADDRESS !== e.addr) begin
                n_fail++;
                $display("FAIL %s: got instr=%h pc=%h valid=%b cnt=%0d addr=%0d, want instr=%h pc=%h valid=%b cnt=%0d addr=%0d",
                         nm, INSTRUCTION, PC_OUT, VALID, FETCH_COUNT, ROM_ADDRESS,
                         e.instr, e.pc, e.valid, e.cnt, e.addr);
            end
        end
    end

    task automatic step(input logic rst, input logic stl, input logic br,
                        input logic [31:0] tgt, input string nm,
                        input logic [31:0] e_instr, input logic [31:0] e_pc,
                        input logic e_valid, input logic [31:0] e_cnt,
                        input logic [9:0] e_addr);
        exp_t e;
        RESET         = rst;
        STALL         = stl;
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
        @(posedge CLK);
        e.instr = e_instr;
        e.pc    = e_pc;
        e.valid = e_valid;
        e.cnt   = e_cnt;
        e.addr  = e_addr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + i;
        rom[0] = 32'h0000_0013;
        rom[1] = 32'h0010_0093;
        rom[2] = 32'h0010_0313;
        rom[3] = 32'h0040_0613;
        rom[4] = 32'h0060_2023;

        //    rst  stl  br   target        name          instr         pc_out        v   cnt     addr
        step(1'b1, 1'b0, 1'b0, 32'h0,   "reset0",     NOP,          32'h0,        0,  32'd0,  10'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0,   "reset1",     NOP,          32'h0,        0,  32'd0,  10'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "stream0",    32'h00000013, 32'h0,        1,  32'd1,  10'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "stream1",    32'h00100093, 32'h4,        1,  32'd2,  10'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "stream2",    32'h00100313, 32'h8,        1,  32'd3,  10'd3);
        step(1'b0, 1'b1, 1'b0, 32'h0,   "stall0",     32'h00100313, 32'h8,        1,  32'd3,  10'd3);
        step(1'b0, 1'b1, 1'b0, 32'h0,   "stall1",     32'h00100313, 32'h8,        1,  32'd3,  10'd3);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "unstall",    32'h00400613, 32'hC,        1,  32'd4,  10'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "stream4",    32'h00602023, 32'h10,       1,  32'd5,  10'd5);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "stream5",    32'h10000005, 32'h14,       1,  32'd6,  10'd6);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "stream6",    32'h10000006, 32'h18,       1,  32'd7,  10'd7);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "stream7",    32'h10000007, 32'h1C,       1,  32'd8,  10'd8);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "stream8",    32'h10000008, 32'h20,       1,  32'd9,  10'd9);
        step(1'b0, 1'b0, 1'b1, 32'h14,  "branch",     NOP,          32'h0,        0,  32'd9,  10'd5);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "branch_tgt", 32'h10000005, 32'h14,       1,  32'd10, 10'd6);
        step(1'b0, 1'b1, 1'b1, 32'h8,   "br_stall",   NOP,          32'h0,        0,  32'd10, 10'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "br_st_tgt",  32'h00100313, 32'h8,        1,  32'd11, 10'd3);
        step(1'b0, 1'b0, 1'b1, 32'hFFE, "misalign",   NOP,          32'h0,        0,  32'd11, 10'd1023);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "rom_top",    32'h100003FF, 32'hFFC,      1,  32'd12, 10'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "rom_alias",  32'h00000013, 32'h1000,     1,  32'd13, 10'd1);
        step(1'b0, 1'b0, 1'b1, 32'h40,  "to_0x40",    NOP,          32'h0,        0,  32'd13, 10'd16);
        step(1'b1, 1'b1, 1'b1, 32'h80,  "mid_reset",  NOP,          32'h0,        0,  32'd0,  10'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0,   "post_reset", 32'h00000013, 32'h0,        1,  32'd1,  10'd1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
